// File: rtl/crypto_pkg.sv
`default_nettype none
// ============================================================================
// crypto_pkg: shared types and constants for the byte-chained XOR sequencer
// Revision: 1.0
// ============================================================================
package crypto_pkg;

  localparam logic [7:0] IV_DEFAULT = 8'h9B;
  localparam logic       MODE_ENC   = 1'b0;
  localparam logic       MODE_DEC   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/crypto_byte_xor.sv
`default_nettype none
// ============================================================================
// crypto_byte_xor: one byte of prev^data^key plus the chaining byte for the next step
// Revision: 1.0
// ============================================================================
module crypto_byte_xor
  import crypto_pkg::*;
(
  input  logic [7:0] i_prev,
  input  logic [7:0] i_data,
  input  logic [7:0] i_key,
  input  logic       i_mode,
  output logic [7:0] o_result,
  output logic [7:0] o_next_prev
);

  assign o_result    = i_prev ^ i_data ^ i_key;
  // The chain always carries ciphertext: the result when encrypting, the input when decrypting
  assign o_next_prev = (i_mode == MODE_DEC) ? i_data : o_result;

endmodule
`default_nettype wire

// File: rtl/crypto_word_sequencer.sv
`default_nettype none
// ============================================================================
// crypto_word_sequencer: processes one 32-bit word per 5 clocks, LSB byte first,
// with optional ciphertext chaining between words
// Revision: 1.0
// ============================================================================
module crypto_word_sequencer
  import crypto_pkg::*;
#(
  parameter logic [7:0] IV          = IV_DEFAULT,
  parameter bit         CHAIN_WORDS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_key,
  input  logic        in_mode,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_mode,
  output logic        busy,
  output logic [1:0]  byte_idx
);

  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic [1:0]  r_idx;
  logic [31:0] r_data;
  logic [31:0] r_key;
  logic [31:0] r_out;
  logic        r_mode;
  logic [7:0]  r_prev;
  logic [7:0]  r_chain;

  logic        w_accept;
  logic        w_out_hs;
  logic [4:0]  w_bit_ofs;
  logic [7:0]  w_res;
  logic [7:0]  w_next_prev;

  assign w_accept  = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;
  assign w_bit_ofs = {r_idx, 3'b000};

  crypto_byte_xor u_byte_xor (
    .i_prev      (r_prev),
    .i_data      (r_data[w_bit_ofs +: 8]),
    .i_key       (r_key[w_bit_ofs +: 8]),
    .i_mode      (r_mode),
    .o_result    (w_res),
    .o_next_prev (w_next_prev)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (r_idx == 2'd3) w_state_nxt = DONE;
      DONE:    if (w_out_hs) w_state_nxt = w_accept ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_data  <= 32'd0;
      r_key   <= 32'd0;
      r_mode  <= MODE_ENC;
      r_out   <= 32'd0;
      r_prev  <= IV;
      r_chain <= IV;
    end else if (w_accept) begin
      r_data  <= in_data;
      r_key   <= in_key;
      r_mode  <= in_mode;
      r_out   <= 32'd0;
      r_idx   <= 2'd0;
      r_prev  <= in_sof ? IV : r_chain;
    end else if (r_state == RUN) begin
      r_out[w_bit_ofs +: 8] <= w_res;
      r_prev                <= w_next_prev;
      r_idx                 <= r_idx + 2'd1;
      if (r_idx == 2'd3) r_chain <= CHAIN_WORDS ? w_next_prev : IV;
    end
  end

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) | (r_state == DONE);
  assign byte_idx  = (r_state == RUN) ? r_idx : 2'd0;
  assign out_data  = r_out;
  assign out_mode  = r_mode;

endmodule
`default_nettype wire
